instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 28 ++
 rtl/instr_field_packer.sv | 54 +++++
 rtl/instr_encoder.sv | 127 ++++++++++++
 tb/tb_instr_encoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared types and constants for the instruction encoder
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_S = 3'd1,
    FMT_B = 3'd2,
    FMT_U = 3'd3,
    FMT_J = 3'd4,
    FMT_R = 3'd5
  } fmt_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;
  localparam logic [1:0] ERR_MISALIGN = 2'b11;

  localparam logic [6:0] OP_SHIFT_IMM = 7'b0010011;

endpackage

// File: rtl/instr_field_packer.sv
// rtl/instr_field_packer.sv - combinational packing of instruction fields into a 32-bit word
// Also flags illegal format codes and odd branch/jump offsets.
module instr_field_packer
  import instr_encoder_pkg::*;
#(
  parameter int OP_WIDTH = 7
) (
  input  logic [2:0]          i_fmt,
  input  logic [OP_WIDTH-1:0] i_op,
  input  logic [4:0]          i_rd,
  input  logic [4:0]          i_rs1,
  input  logic [4:0]          i_rs2,
  input  logic [2:0]          i_funct3,
  input  logic                i_funct7b5,
  input  logic [31:0]         i_imm,
  output logic [31:0]         o_word,
  output logic                o_illegal,
  output logic                o_misaligned
);

  logic [6:0] w_op7;
  logic       w_shift_imm;

  assign w_op7       = 7'(i_op);
  // Immediate shifts carry shamt in imm[4:0] and reuse the R-type funct7 layout
  assign w_shift_imm = (w_op7 == OP_SHIFT_IMM) && ((i_funct3 == 3'b001) || (i_funct3 == 3'b101));

  always_comb begin
    o_word       = 32'd0;
    o_illegal    = 1'b0;
    o_misaligned = 1'b0;
    case (i_fmt)
      FMT_I: begin
        if (w_shift_imm)
          o_word = {1'b0, i_funct7b5, 5'b00000, i_imm[4:0], i_rs1, i_funct3, i_rd, w_op7};
        else
          o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, w_op7};
      end
      FMT_S: o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], w_op7};
      FMT_B: begin
        o_word       = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], w_op7};
        o_misaligned = i_imm[0];
      end
      FMT_U: o_word = {i_imm[31:12], i_rd, w_op7};
      FMT_J: begin
        o_word       = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, w_op7};
        o_misaligned = i_imm[0];
      end
      FMT_R: o_word = {1'b0, i_funct7b5, 5'b00000, i_rs2, i_rs1, i_funct3, i_rd, w_op7};
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - session FSM that encodes field bundles and writes them to instruction memory
// One word per two cycles: accept in RUN, write in WRITE.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int OP_WIDTH   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [2:0]            fmt,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic [31:0]           imm,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err
);

  state_e                r_state;
  state_e                w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_word;
  logic                  r_last;
  logic [1:0]            r_err;

  logic [31:0]           w_word;
  logic                  w_illegal;
  logic                  w_misaligned;
  logic                  w_start_ok;
  logic                  w_xfer;
  logic                  w_addr_max;

  instr_field_packer #(
    .OP_WIDTH(OP_WIDTH)
  ) u_packer (
    .i_fmt       (fmt),
    .i_op        (op),
    .i_rd        (rd),
    .i_rs1       (rs1),
    .i_rs2       (rs2),
    .i_funct3    (funct3),
    .i_funct7b5  (funct7b5),
    .i_imm       (imm),
    .o_word      (w_word),
    .o_illegal   (w_illegal),
    .o_misaligned(w_misaligned)
  );

  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_xfer     = in_valid && (r_state == ST_RUN);
  assign w_addr_max = (r_addr == {ADDR_WIDTH{1'b1}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: if (w_start_ok) w_next_state = ST_RUN;
      ST_RUN: begin
        if (w_xfer) begin
          if (w_illegal || w_misaligned) w_next_state = ST_ERR;
          else                           w_next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (r_last)          w_next_state = ST_DONE;
        else if (w_addr_max) w_next_state = ST_ERR;
        else                 w_next_state = ST_RUN;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (r_state == ST_RUN);
    imem_we    = (r_state == ST_WRITE);
    busy       = (r_state == ST_RUN) || (r_state == ST_WRITE);
    done       = (r_state == ST_DONE);
    imem_addr  = r_addr;
    imem_wdata = r_word;
    err        = r_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
      r_word <= 32'd0;
      r_last <= 1'b0;
      r_err  <= ERR_NONE;
    end else begin
      if (w_start_ok) begin
        r_addr <= base_addr;
        r_err  <= ERR_NONE;
      end
      if (w_xfer) begin
        if (w_illegal)         r_err <= ERR_ILLEGAL;
        else if (w_misaligned) r_err <= ERR_MISALIGN;
        else begin
          r_word <= w_word;
          r_last <= in_last;
        end
      end
      // Counter saturates at all-ones; a further bundle is reported as overflow
      if (r_state == ST_WRITE) begin
        if (!w_addr_max)           r_addr <= r_addr + ADDR_WIDTH'(1);
        if (!r_last && w_addr_max) r_err  <= ERR_OVERFLOW;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [2:0]  fmt;
  logic [6:0]  op;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] imm;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic [1:0]  err;

  int n_vec;
  int n_miss;
  int wr_count;
  int w0;

  instr_encoder #(
    .ADDR_WIDTH(8),
    .OP_WIDTH  (7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .fmt       (fmt),
    .op        (op),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .imm       (imm),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (imem_we) wr_count++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] b);
    start     = 1'b1;
    base_addr = b;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic send_bundle(input logic [2:0] f, input logic [6:0] o, input logic [4:0] d,
                             input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                             input logic f7, input logic [31:0] im, input logic lst);
    int n;
    fmt = f; op = o; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7b5 = f7; imm = im;
    in_last  = lst;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [7:0] a, input logic [31:0] d);
    check_eq({tag, "_we"}, 32'(imem_we), 32'd1);
    check_eq({tag, "_addr"}, 32'(imem_addr), 32'(a));
    check_eq({tag, "_data"}, imem_wdata, d);
  endtask

  initial begin
    n_vec = 0; n_miss = 0; wr_count = 0; w0 = 0;
    rst = 1'b0; start = 1'b0; base_addr = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    fmt = 3'd0; op = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0;
    funct7b5 = 1'b0; imm = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_we", 32'(imem_we), 32'd0);
    check_eq("rst_addr", 32'(imem_addr), 32'd0);
    check_eq("rst_wdata", imem_wdata, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // single addi session
    do_start(8'h10);
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_ready", 32'(in_ready), 32'd1);
    send_bundle(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1);
    expect_write("t1", 8'h10, 32'h00500093);
    @(negedge clk);
    check_eq("t1_done", 32'(done), 32'd1);
    check_eq("t1_busy_end", 32'(busy), 32'd0);
    check_eq("t1_we_end", 32'(imem_we), 32'd0);

    // R / S / B / J stream at consecutive addresses
    do_start(8'h00);
    send_bundle(3'd5, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 1'b0);
    expect_write("t2_sub", 8'h00, 32'h402081B3);
    @(negedge clk);
    check_eq("t2_ready_n2", 32'(in_ready), 32'd1);
    check_eq("t2_we_n2", 32'(imem_we), 32'd0);
    send_bundle(3'd1, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 1'b0, 32'd8, 1'b0);
    expect_write("t2_sw", 8'h01, 32'h00512423);
    @(negedge clk);
    send_bundle(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFC, 1'b0);
    expect_write("t2_beq", 8'h02, 32'hFE000EE3);
    @(negedge clk);
    send_bundle(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8, 1'b1);
    expect_write("t2_jal", 8'h03, 32'h008000EF);
    @(negedge clk);
    check_eq("t2_done", 32'(done), 32'd1);

    // shift-immediate and U-type
    do_start(8'h30);
    send_bundle(3'd0, 7'h13, 5'd5, 5'd6, 5'd0, 3'd5, 1'b1, 32'h0000_07E3, 1'b0);
    expect_write("t3_srai", 8'h30, 32'h40335293);
    @(negedge clk);
    send_bundle(3'd3, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000, 1'b1);
    expect_write("t3_lui", 8'h31, 32'h123453B7);
    @(negedge clk);
    check_eq("t3_done", 32'(done), 32'd1);

    // illegal format and misaligned branch
    do_start(8'h20);
    w0 = wr_count;
    send_bundle(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0);
    expect_write("t4_ok", 8'h20, 32'h00500093);
    @(negedge clk);
    send_bundle(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0);
    check_eq("t4_ill_we", 32'(imem_we), 32'd0);
    check_eq("t4_ill_err", 32'(err), 32'd1);
    check_eq("t4_ill_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("t4_ill_writes", 32'(wr_count - w0), 32'd1);
    check_eq("t4_ill_hold", 32'(err), 32'd1);
    do_start(8'h21);
    check_eq("t4_clr_err", 32'(err), 32'd0);
    check_eq("t4_clr_ready", 32'(in_ready), 32'd1);
    send_bundle(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3, 1'b0);
    check_eq("t4_mis_err", 32'(err), 32'd3);
    check_eq("t4_mis_we", 32'(imem_we), 32'd0);
    do_start(8'h22);
    check_eq("t4_clr2_err", 32'(err), 32'd0);
    send_bundle(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1);
    expect_write("t4_after", 8'h22, 32'h00500093);
    @(negedge clk);

    // counter overflow at all-ones
    do_start(8'hFF);
    w0 = wr_count;
    send_bundle(3'd0, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1, 1'b0);
    expect_write("t5", 8'hFF, 32'h00100113);
    @(negedge clk);
    check_eq("t5_err", 32'(err), 32'd2);
    check_eq("t5_ready", 32'(in_ready), 32'd0);
    check_eq("t5_addr", 32'(imem_addr), 32'hFF);
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("t5_ready_hold", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    check_eq("t5_writes", 32'(wr_count - w0), 32'd1);

    // reset during WRITE, then start ignored mid-RUN
    do_start(8'h40);
    w0 = wr_count;
    send_bundle(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0);
    check_eq("t6_in_write", 32'(imem_we), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("t6_rst_ready", 32'(in_ready), 32'd0);
    check_eq("t6_rst_we", 32'(imem_we), 32'd0);
    check_eq("t6_rst_addr", 32'(imem_addr), 32'd0);
    check_eq("t6_rst_wdata", imem_wdata, 32'd0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_done", 32'(done), 32'd0);
    check_eq("t6_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("t6_idle_busy", 32'(busy), 32'd0);
    check_eq("t6_idle_ready", 32'(in_ready), 32'd0);
    check_eq("t6_writes", 32'(wr_count - w0), 32'd1);
    do_start(8'h50);
    do_start(8'h60);
    send_bundle(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1);
    expect_write("t6_ign", 8'h50, 32'h00500093);
    @(negedge clk);
    check_eq("t6_done", 32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
